// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped UART transmitter that sits on the CPU data-memory bus.
// Stores to TXDATA queue bytes in a small FIFO. A serialiser sends each byte
// as an 8N1 frame, or as an 8E1 frame when MMIO_UART_TX_PARITY_EN is defined.
// Loads return STATUS and CTRL so firmware can poll before writing.
//
// Configuration macro:
//   MMIO_UART_TX_PARITY_EN  adds an even-parity bit between the data and stop bits
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   asynchronous active-high reset
//   mem_write   in   store strobe
//   mem_read    in   load strobe
//   address     in   byte address (bits [1:0] ignored)
//   write_data  in   store data
//   read_data   out  combinational load data (0 unless sel && mem_read)
//   sel         out  combinational, address falls in the 16-byte window
//   tx          out  serial line, idles high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          r_parity;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [NW-1:0] r_count;
  logic          r_overrun;
  logic          r_enable;

  logic       w_wr;
  logic       w_push;
  logic       w_pushOk;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic [3:0] w_cnt4;
  logic       w_unused;

  assign sel      = (address[31:4] == BASE_ADDR[31:4]);
  assign w_wr     = sel && mem_write;
  assign w_push   = w_wr && (address[3:2] == 2'd0);
  assign w_full   = (r_count == COUNT_FULL);
  assign w_empty  = (r_count == '0);
  // Full is judged on the pre-edge count, so a push coinciding with a pop
  // from a full FIFO is still dropped.
  assign w_pushOk = w_push && !w_full;
  assign w_pop    = (r_state == IDLE) && r_enable && !w_empty;
  assign w_busy   = (r_state != IDLE);
  assign w_cnt4   = 4'(r_count);
  assign w_unused = ^{address[1:0], write_data[31:8]};
  assign tx       = r_tx;

  // Register read mux.
  always_comb begin
    read_data = '0;
    if (sel && mem_read) begin
      case (address[3:2])
        2'd1:    read_data = {24'd0, w_cnt4, r_overrun, w_busy, w_empty, w_full};
        2'd2:    read_data = {31'd0, r_enable};
        default: read_data = '0;
      endcase
    end
  end

  // FIFO storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= write_data[7:0];
    end
  end

  // FIFO pointers, count, sticky overrun and the enable control bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_enable  <= 1'b1;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= r_count + NW'(w_pushOk) - NW'(w_pop);
      if (w_push && w_full) begin
        r_overrun <= 1'b1;
      end else if (w_wr && (address[3:2] == 2'd1) && write_data[3]) begin
        r_overrun <= 1'b0;
      end
      if (w_wr && (address[3:2] == 2'd2)) begin
        r_enable <= write_data[0];
      end
    end
  end

  // Serialiser FSM. tx is registered and is loaded with the level of the next
  // state on each transition. An asynchronous reset therefore returns the line
  // high immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_baud <= r_baud + 1'b1;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rdPtr];
`ifdef MMIO_UART_TX_PARITY_EN
            r_parity <= ^r_mem[r_rdPtr];
`endif
            r_state <= START;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_state  <= DATA;
            r_tx     <= r_shift[0];
          end
        end
        DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bitIdx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Frames are captured from the tx line and compared with bytes taken from a
// queue-based model of the FIFO and the STATUS register.
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_CTRL   = BASE + 32'h8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_PERIOD = FRAME_BITS * CPB + 1;

  logic        clock;
  logic        reset;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        sel;
  logic        tx;

  int checks;
  int failures;
  int cycleCount;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_write(mem_write),
    .mem_read(mem_read),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .sel(sel),
    .tx(tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Expected STATUS value from the model's view of the queue.
  function automatic logic [31:0] statusOf(input int cnt, input logic ovr, input logic busy);
    return 32'(cnt * 16 + (ovr ? 8 : 0) + (busy ? 4 : 0) + ((cnt == 0) ? 2 : 0) + ((cnt == DEPTH) ? 1 : 0));
  endfunction

  function automatic logic evenParity(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  // Stores happen at the first rising edge after the call. Each call starts
  // and ends on a falling edge.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    address    = a;
    write_data = d;
    mem_write  = 1'b1;
    @(negedge clock);
    mem_write  = 1'b0;
    write_data = '0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    address  = a;
    mem_read = 1'b1;
    #1;
    d = read_data;
    mem_read = 1'b0;
  endtask

  // Waits, within a bounded time, for a start bit. The frame is then sampled
  // at bit centres. The call returns in the middle of the stop bit.
  task automatic captureFrame(output logic [7:0] data, output logic found, output int startAt,
                              output logic startBit, output logic parityBit, output logic stopBit);
    found = 1'b0; data = '0; startAt = 0; startBit = 1'b1; parityBit = 1'b0; stopBit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!found) return;
    startAt = cycleCount;
    repeat (CPB / 2) @(negedge clock);
    startBit = tx;
    for (int b = 0; b < 8; b++) begin
      repeat (CPB) @(negedge clock);
      data[b] = tx;
    end
`ifdef MMIO_UART_TX_PARITY_EN
    repeat (CPB) @(negedge clock);
    parityBit = tx;
`endif
    repeat (CPB) @(negedge clock);
    stopBit = tx;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    #2;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx actual=%b expected=1", tx); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("[TB] FAIL reset_status actual=%h expected=02", d); end
    peek(A_CTRL, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("[TB] FAIL reset_ctrl actual=%h expected=1", d); end
    @(negedge clock);
  endtask

  task automatic test_single_byte;
    logic [7:0] data; logic found, sb, pb, stb; int st; logic [31:0] d;
    busWrite(A_TXDATA, 32'hABCD_EF55);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL single_pre_start actual=%b expected=1", tx); end
    @(negedge clock);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("[TB] FAIL single_start_latency actual=%b expected=0", tx); end
    captureFrame(data, found, st, sb, pb, stb);
    checks++;
    if (!found || data !== 8'h55 || sb !== 1'b0 || stb !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_frame actual=%h start=%b stop=%b found=%b expected=55 start=0 stop=1", data, sb, stb, found);
    end
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h06) begin failures++; $display("[TB] FAIL single_status_mid actual=%h expected=06", d); end
    repeat (4) @(negedge clock);
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("[TB] FAIL single_status_end actual=%h expected=02", d); end
    @(negedge clock);
  endtask

  task automatic test_overflow;
    logic [7:0] q[$]; logic [7:0] data, expb; logic found, sb, pb, stb; int st, prevSt; logic [31:0] d;
    busWrite(A_CTRL, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      busWrite(A_TXDATA, 32'(i * 8'h11));
      if (q.size() < DEPTH) q.push_back(8'(i * 8'h11));
    end
    peek(A_STATUS, d);
    checks++;
    if (d !== statusOf(4, 1'b1, 1'b0)) begin failures++; $display("[TB] FAIL overflow_status actual=%h expected=%h", d, statusOf(4, 1'b1, 1'b0)); end
    busWrite(A_STATUS, 32'h8);
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h41) begin failures++; $display("[TB] FAIL overflow_clear actual=%h expected=41", d); end
    // Enable, then push at the same edge as the first pop. The FIFO is still
    // full before that edge, so the byte must be dropped.
    busWrite(A_CTRL, 32'h1);
    busWrite(A_TXDATA, 32'h99);
    peek(A_STATUS, d);
    checks++;
    if (d !== statusOf(3, 1'b1, 1'b1)) begin failures++; $display("[TB] FAIL overflow_push_pop actual=%h expected=%h", d, statusOf(3, 1'b1, 1'b1)); end
    prevSt = 0;
    for (int f = 0; f < 4; f++) begin
      expb = q.pop_front();
      captureFrame(data, found, st, sb, pb, stb);
      checks++;
      if (!found || data !== expb || sb !== 1'b0 || stb !== 1'b1) begin
        failures++;
        $display("[TB] FAIL overflow_frame%0d actual=%h found=%b expected=%h", f, data, found, expb);
      end
      if (f > 0) begin
        checks++;
        if (st - prevSt !== FRAME_PERIOD) begin failures++; $display("[TB] FAIL overflow_gap%0d actual=%0d expected=%0d", f, st - prevSt, FRAME_PERIOD); end
      end
      prevSt = st;
    end
    repeat (4) @(negedge clock);
    busWrite(A_STATUS, 32'h8);
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("[TB] FAIL overflow_final actual=%h expected=02", d); end
    @(negedge clock);
  endtask

`ifdef MMIO_UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] data; logic found, sb, pb, stb; int st;
    logic [7:0] bytesIn [2];
    bytesIn[0] = 8'h07;
    bytesIn[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      busWrite(A_TXDATA, 32'(bytesIn[k]));
      captureFrame(data, found, st, sb, pb, stb);
      checks++;
      if (!found || data !== bytesIn[k] || pb !== evenParity(bytesIn[k]) || stb !== 1'b1) begin
        failures++;
        $display("[TB] FAIL parity_frame%0d actual=%h par=%b expected=%h par=%b", k, data, pb, bytesIn[k], evenParity(bytesIn[k]));
      end
      repeat (4) @(negedge clock);
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [31:0] d; logic sawLow;
    busWrite(A_TXDATA, 32'h0);
    busWrite(A_TXDATA, 32'h0);
    repeat (17) @(negedge clock);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("[TB] FAIL midreset_pre actual=%b expected=0", tx); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL midreset_async_tx actual=%b expected=1", tx); end
    @(negedge clock);
    reset = 1'b0;
    sawLow = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) sawLow = 1'b1;
    end
    checks++;
    if (sawLow !== 1'b0) begin failures++; $display("[TB] FAIL midreset_no_frame actual=%b expected=0", sawLow); end
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("[TB] FAIL midreset_status actual=%h expected=02", d); end
    @(negedge clock);
  endtask

  task automatic test_decode;
    logic [31:0] d; logic sawLow;
    peek(BASE + 32'hC, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL decode_reg_c actual=%h expected=0", d); end
    address = BASE + 32'hC;
    #1;
    checks++;
    if (sel !== 1'b1) begin failures++; $display("[TB] FAIL decode_sel_in actual=%b expected=1", sel); end
    address = BASE + 32'h10;
    #1;
    checks++;
    if (sel !== 1'b0) begin failures++; $display("[TB] FAIL decode_sel_out actual=%b expected=0", sel); end
    peek(BASE + 32'h14, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL decode_read_out actual=%h expected=0", d); end
    @(negedge clock);
    busWrite(BASE + 32'h10, 32'hAB);
    busWrite(BASE + 32'h18, 32'h0);
    sawLow = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) sawLow = 1'b1;
    end
    checks++;
    if (sawLow !== 1'b0) begin failures++; $display("[TB] FAIL decode_no_tx actual=%b expected=0", sawLow); end
    peek(A_STATUS, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("[TB] FAIL decode_status actual=%h expected=02", d); end
    peek(A_CTRL, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("[TB] FAIL decode_ctrl actual=%h expected=1", d); end
    address = A_STATUS;
    #1;
    checks++;
    if (read_data !== 32'h0) begin failures++; $display("[TB] FAIL decode_no_read actual=%h expected=0", read_data); end
    @(negedge clock);
  endtask

  task automatic test_random;
    logic [7:0] q[$]; logic ovr; logic [7:0] b, data, expb; logic found, sb, pb, stb; int st, n;
    logic [31:0] d;
    for (int round = 0; round < 4; round++) begin
      q.delete();
      ovr = 1'b0;
      busWrite(A_CTRL, 32'h0);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        busWrite(A_TXDATA, {24'($urandom), b});
        if (q.size() < DEPTH) q.push_back(b);
        else ovr = 1'b1;
      end
      peek(A_STATUS, d);
      checks++;
      if (d !== statusOf(q.size(), ovr, 1'b0)) begin
        failures++;
        $display("[TB] FAIL random%0d_status actual=%h expected=%h", round, d, statusOf(q.size(), ovr, 1'b0));
      end
      busWrite(A_STATUS, 32'h8);
      busWrite(A_CTRL, 32'h1);
      while (q.size() > 0) begin
        expb = q.pop_front();
        captureFrame(data, found, st, sb, pb, stb);
        checks++;
        if (!found || data !== expb || sb !== 1'b0 || stb !== 1'b1
`ifdef MMIO_UART_TX_PARITY_EN
            || pb !== evenParity(expb)
`endif
           ) begin
          failures++;
          $display("[TB] FAIL random%0d_frame actual=%h found=%b expected=%h", round, data, found, expb);
        end
      end
      repeat (6) @(negedge clock);
      peek(A_STATUS, d);
      checks++;
      if (d !== 32'h02) begin failures++; $display("[TB] FAIL random%0d_final actual=%h expected=02", round, d); end
      @(negedge clock);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cycleCount = 0;
    reset      = 1'b1;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = '0;
    write_data = '0;
    test_reset;
    test_single_byte;
    test_overflow;
`ifdef MMIO_UART_TX_PARITY_EN
    test_parity;
`endif
    test_reset_mid_frame;
    test_decode;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
